// File: rtl/npu_act_wr_arbiter_if.sv
// Activation write bus: 32 neuron request channels plus the shared memory write port.
// master = arbiter side, slave = neurons/memory side.
interface npu_act_wr_arbiter_if #(
    parameter int NUM_CH = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        hw_mem_wr;
    logic [NUM_CH*ADDR_W-1:0] hw_mem_wr_addr;
    logic [NUM_CH*DATA_W-1:0] hw_mem_wr_data;
    logic [NUM_CH-1:0]        hw_mem_wr_ack_p;
    logic                     mem_busy;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;

    modport master (
        input  hw_mem_wr,
        input  hw_mem_wr_addr,
        input  hw_mem_wr_data,
        input  mem_busy,
        output hw_mem_wr_ack_p,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output hw_mem_wr,
        output hw_mem_wr_addr,
        output hw_mem_wr_data,
        output mem_busy,
        input  hw_mem_wr_ack_p,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter serialising neuron activation writes onto one memory port, with per-layer write counting.
// Optional write-overflow check enabled by defining NPU_ACT_WR_OVF_CHK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate; grant when a request is pending and mem_busy=0
// ST_WRITE | one-cycle memory write and ack to the granted channel
module npu_act_wr_arbiter #(
    parameter int NUM_CH = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 layer_start_p,
    input  logic [15:0]          exp_wr_cnt,
    npu_act_wr_arbiter_if.master bus,
    output logic                 layer_wr_done_p,
    output logic                 wr_ovf_err
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [15:0]       exp_q, exp_d;
    logic              done_armed_q, done_armed_d;

    logic              win_vld;
    logic [CH_W-1:0]   win_idx;
    logic              is_write;
    logic              done_hit;
    logic [NUM_CH-1:0] ack;

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return CH_W'(sum);
    endfunction

    // First pending request at or above rr_ptr, wrapping past the top channel.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_vld && bus.hw_mem_wr[wrap_idx(rr_ptr_q, i)]) begin
                win_vld = 1'b1;
                win_idx = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.mem_busy && win_vld) begin
                    state_d   = ST_WRITE;
                    gnt_idx_d = win_idx;
                    addr_d    = bus.hw_mem_wr_addr[ADDR_W*int'(win_idx) +: ADDR_W];
                    data_d    = bus.hw_mem_wr_data[DATA_W*int'(win_idx) +: DATA_W];
                    rr_ptr_d  = (win_idx == CH_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign is_write = (state_q == ST_WRITE);
    assign done_hit = done_armed_q && (wr_cnt_q == exp_q);

    // A layer start wins over a coincident write, which then counts as the first write of the new layer.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        exp_d        = exp_q;
        done_armed_d = done_armed_q;
        if (layer_start_p) begin
            wr_cnt_d     = is_write ? 16'd1 : 16'd0;
            exp_d        = exp_wr_cnt;
            done_armed_d = 1'b1;
        end else begin
            if (is_write && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
            if (done_hit) begin
                done_armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            gnt_idx_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_cnt_q     <= '0;
            exp_q        <= '0;
            done_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_cnt_q     <= wr_cnt_d;
            exp_q        <= exp_d;
            done_armed_q <= done_armed_d;
        end
    end

    always_comb begin
        ack = '0;
        if (is_write) begin
            ack[gnt_idx_q] = 1'b1;
        end
    end

    assign bus.hw_mem_wr_ack_p = ack;
    assign bus.mem_we          = is_write;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = data_q;
    assign layer_wr_done_p     = done_hit;

`ifdef NPU_ACT_WR_OVF_CHK_EN
    logic wr_ovf_err_q, wr_ovf_err_d;

    // Sticky across layers; only reset clears it.
    always_comb begin
        wr_ovf_err_d = wr_ovf_err_q;
        if (is_write && !done_armed_q && (wr_cnt_q >= exp_q)) begin
            wr_ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ovf_err_q <= 1'b0;
        end else begin
            wr_ovf_err_q <= wr_ovf_err_d;
        end
    end

    assign wr_ovf_err = wr_ovf_err_q;
`else
    assign wr_ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Directed self-checking bench for npu_act_wr_arbiter; the neuron model drops a request on its ack.
module tb_npu_act_wr_arbiter;
    localparam int NUM_CH = 32;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
`ifdef NPU_ACT_WR_OVF_CHK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        layer_start_p = 1'b0;
    logic [15:0] exp_wr_cnt = 16'd0;
    logic        layer_wr_done_p;
    logic        wr_ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    npu_act_wr_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    npu_act_wr_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .layer_start_p   (layer_start_p),
        .exp_wr_cnt      (exp_wr_cnt),
        .bus             (bus),
        .layer_wr_done_p (layer_wr_done_p),
        .wr_ovf_err      (wr_ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_raw();
        bus.hw_mem_wr = bus.hw_mem_wr & ~bus.hw_mem_wr_ack_p;
    endtask

    task automatic set_req(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.hw_mem_wr[ch] = 1'b1;
        bus.hw_mem_wr_addr[ADDR_W*ch +: ADDR_W] = a;
        bus.hw_mem_wr_data[DATA_W*ch +: DATA_W] = d;
    endtask

    task automatic wait_ack(input string tag, input int ch, input int max_cyc);
        int n;
        n = 0;
        do begin
            tick_raw();
            n++;
        end while ((bus.hw_mem_wr_ack_p == '0) && (n < max_cyc));
        check_val(tag, 64'(bus.hw_mem_wr_ack_p), 64'(1) << ch);
        bus.hw_mem_wr = bus.hw_mem_wr & ~bus.hw_mem_wr_ack_p;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_layer(input logic [15:0] n);
        layer_start_p = 1'b1;
        exp_wr_cnt    = n;
        tick();
        layer_start_p = 1'b0;
    endtask

    initial begin
        int k;
        logic exp_done [7];

        bus.hw_mem_wr      = '0;
        bus.hw_mem_wr_addr = '0;
        bus.hw_mem_wr_data = '0;
        bus.mem_busy       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_we",   64'(bus.mem_we), 64'd0);
        check_val("rst_ack",  64'(bus.hw_mem_wr_ack_p), 64'd0);
        check_val("rst_addr", 64'(bus.mem_addr), 64'd0);
        check_val("rst_data", 64'(bus.mem_wdata), 64'd0);
        check_val("rst_done", 64'(layer_wr_done_p), 64'd0);
        check_val("rst_ovf",  64'(wr_ovf_err), 64'd0);
        rst = 1'b1;

        // single request on channel 5
        set_req(5, 10'h03A, 8'h7F);
        tick();
        check_val("single_we",   64'(bus.mem_we), 64'd1);
        check_val("single_addr", 64'(bus.mem_addr), 64'h03A);
        check_val("single_data", 64'(bus.mem_wdata), 64'h7F);
        check_val("single_ack",  64'(bus.hw_mem_wr_ack_p), 64'h0000_0020);
        tick();
        check_val("single_ack_drop", 64'(bus.hw_mem_wr_ack_p), 64'd0);
        check_val("single_we_drop",  64'(bus.mem_we), 64'd0);
        check_val("single_addr_hold", 64'(bus.mem_addr), 64'h03A);
        check_val("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd6);

        // full contention from a fresh rr_ptr
        do_reset();
        for (int j = 0; j < NUM_CH; j++) begin
            set_req(j, ADDR_W'(j), DATA_W'(j + 64));
        end
        k = 0;
        for (int c = 1; c <= 64; c++) begin
            tick_raw();
            if (bus.hw_mem_wr_ack_p != '0) begin
                check_val("cont_ack",  64'(bus.hw_mem_wr_ack_p), 64'(1) << k);
                check_val("cont_cyc",  64'(c), 64'(2 * k + 1));
                check_val("cont_data", 64'(bus.mem_wdata), 64'(k + 64));
                k++;
                bus.hw_mem_wr = bus.hw_mem_wr & ~bus.hw_mem_wr_ack_p;
            end
        end
        check_val("cont_total", 64'(k), 64'd32);
        check_val("cont_req_left", 64'(bus.hw_mem_wr), 64'd0);
        check_val("cont_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        // wrap: rr_ptr=30, requests on 2 and 31
        set_req(29, 10'h1D, 8'h29);
        wait_ack("wrap_ack29", 29, 6);
        check_val("wrap_rr_ptr", 64'(dut.rr_ptr_q), 64'd30);
        set_req(2, 10'h002, 8'h02);
        set_req(31, 10'h01F, 8'h31);
        wait_ack("wrap_first_31", 31, 4);
        check_val("wrap_addr31", 64'(bus.mem_addr), 64'h01F);
        wait_ack("wrap_then_2", 2, 4);
        check_val("wrap_addr2", 64'(bus.mem_addr), 64'h002);

        // mem_busy blocks grants
        bus.mem_busy = 1'b1;
        set_req(7, 10'h155, 8'hA5);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val("busy_no_write", 64'({bus.mem_we, bus.hw_mem_wr_ack_p}), 64'd0);
        end
        bus.mem_busy = 1'b0;
        tick();
        check_val("busy_release_we",  64'(bus.mem_we), 64'd1);
        check_val("busy_release_ack", 64'(bus.hw_mem_wr_ack_p), 64'h0000_0080);
        check_val("busy_release_addr", 64'(bus.mem_addr), 64'h155);
        tick();

        // done pulse after 3 writes
        start_layer(16'd3);
        check_val("done3_initial", 64'(layer_wr_done_p), 64'd0);
        set_req(10, 10'h010, 8'h10);
        set_req(11, 10'h011, 8'h11);
        set_req(12, 10'h012, 8'h12);
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 7; c++) begin
            tick();
            check_val($sformatf("done3_cyc%0d", c), 64'(layer_wr_done_p), 64'(exp_done[c]));
        end

        // done pulse with zero expected writes
        start_layer(16'd0);
        check_val("done0_pulse", 64'(layer_wr_done_p), 64'd1);
        tick();
        check_val("done0_clear", 64'(layer_wr_done_p), 64'd0);

        // layer start coinciding with a write counts it in the new layer
        set_req(15, 10'h015, 8'h15);
        wait_ack("coinc_ack", 15, 4);
        start_layer(16'd1);
        check_val("coinc_done", 64'(layer_wr_done_p), 64'd1);
        tick();
        check_val("coinc_done_clear", 64'(layer_wr_done_p), 64'd0);

        // overflow: expect 2, issue 4
        do_reset();
        check_val("ovf_after_rst", 64'(wr_ovf_err), 64'd0);
        start_layer(16'd2);
        for (int j = 20; j < 24; j++) begin
            set_req(j, ADDR_W'(j), DATA_W'(j));
        end
        repeat (5) tick();
        check_val("ovf_before_3rd", 64'(wr_ovf_err), 64'd0);
        tick();
        check_val("ovf_on_3rd", 64'(wr_ovf_err), 64'(OVF_EXP));
        repeat (2) tick();
        start_layer(16'd5);
        tick();
        check_val("ovf_sticky", 64'(wr_ovf_err), 64'(OVF_EXP));

        // reset asserted in the middle of a write
        set_req(9, 10'h099, 8'h99);
        tick_raw();
        check_val("midrst_we_pre", 64'(bus.mem_we), 64'd1);
        rst = 1'b0;
        #1;
        check_val("midrst_we",  64'(bus.mem_we), 64'd0);
        check_val("midrst_ack", 64'(bus.hw_mem_wr_ack_p), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ack("midrst_reserve", 9, 4);
        check_val("midrst_rr_ptr", 64'(dut.rr_ptr_q), 64'd10);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/npu_act_wr_arbiter.md
Name: npu_act_wr_arbiter

Overview:
- Serialises the per-neuron activation write requests from the 32-neuron layer onto a single activation-memory write port.
- Each neuron holds its hw_mem_wr request until it sees a one-cycle hw_mem_wr_ack_p. This block picks one requester at a time using round-robin, drives the memory write, and returns the ack.
- Counts writes per layer and pulses a done strobe so the layer sequencer can advance to the next layer.

Parameters:
NUM_CH, 32, number of neuron requesters
ADDR_W, 10, activation memory address width (per-channel address field width)
DATA_W, 8, activation data width

Ports:
clk  in  1  clock
rst  in  1  reset
layer_start_p  in  1  pulse; clears write counter, loads exp_wr_cnt
exp_wr_cnt  in  16  number of writes expected for the current layer
hw_mem_wr  in  NUM_CH  per-neuron write request, level, held until acked
hw_mem_wr_addr  in  NUM_CH*ADDR_W  packed addresses, channel j at [ADDR_W*j +: ADDR_W]
hw_mem_wr_data  in  NUM_CH*DATA_W  packed data, channel j at [DATA_W*j +: DATA_W]
hw_mem_wr_ack_p  out  NUM_CH  one-hot one-cycle ack
mem_busy  in  1  shared port in use by host/loader; blocks new grants
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
layer_wr_done_p  out  1  one-cycle pulse when write count reaches expected
wr_ovf_err  out  1  sticky write-overflow error (optional feature)

Interface (decided):
- One clock, clk. Reset rst is asynchronous and active-low.

Behaviour:
- Reset (rst low, async): state=IDLE, rr_ptr=0, wr_cnt=0, exp_reg=0, done_armed=0. All outputs are 0.
- FSM states:
  - IDLE: if mem_busy=0 and |hw_mem_wr, select the winner and go to WRITE. Otherwise stay in IDLE.
  - WRITE: lasts exactly one cycle, then always returns to IDLE.
- Winner selection: the first set bit scanning from index rr_ptr upward, wrapping NUM_CH-1 to 0. This is combinational in IDLE.
- On the IDLE->WRITE edge:
  - Register gnt_idx plus that channel's address and data.
  - rr_ptr <= (gnt_idx+1) mod NUM_CH.
- In WRITE:
  - mem_we=1.
  - mem_addr and mem_wdata carry the registered values.
  - hw_mem_wr_ack_p[gnt_idx]=1; all other ack bits are 0.
- Latency: request seen in IDLE at cycle N produces write + ack at cycle N+1.
- Throughput: at most one write per 2 cycles. The forced return to IDLE guarantees the acked neuron has dropped its request before the next arbitration, so a double grant is impossible.
- mem_busy:
  - Sampled only in IDLE.
  - A WRITE already entered completes even if mem_busy rises during it.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Write counter:
  - wr_cnt increments by 1 on every WRITE cycle.
  - It saturates at 16'hFFFF.
- layer_start_p:
  - Sets wr_cnt=0, exp_reg=exp_wr_cnt, done_armed=1.
  - It does not touch rr_ptr or an in-flight WRITE; that write counts toward the new layer.
- Done: when done_armed=1 and wr_cnt==exp_reg, pulse layer_wr_done_p for 1 cycle and clear done_armed.
  - If exp_wr_cnt=0, the pulse occurs the cycle after layer_start_p.
  - Simultaneous layer_start_p and a WRITE: the start clear takes priority; the WRITE is counted as 1 in the new layer.
- Simultaneous requests from all channels: service order is rr_ptr, rr_ptr+1, ..., wrapping. No channel waits more than NUM_CH grants.
- Reset asserted mid-WRITE:
  - Ack and we drop immediately (async).
  - The neuron keeps its request and is re-served after reset from rr_ptr=0.

Optional Feature:
- Macro: NPU_ACT_WR_OVF_CHK_EN.
- Defined:
  - wr_ovf_err sets when a WRITE occurs while done_armed=0 and wr_cnt>=exp_reg, i.e. more writes than expected in the layer.
  - It stays set until reset; layer_start_p does not clear it.
- Undefined: wr_ovf_err is tied to 0 and no check logic is built.

Test Plan:
- Single request: reset, hw_mem_wr[5]=1, addr=0x03A, data=0x7F.
  - Next cycle: mem_we=1, mem_addr=0x03A, mem_wdata=0x7F, ack_p=32'h0000_0020 for exactly 1 cycle.
  - rr_ptr becomes 6.
- Full contention: all 32 requests held, each dropped on its ack.
  - Acks go to channels 0,1,...,31 in order, one every 2 cycles.
  - 32 writes in 64 cycles; no channel is acked twice.
- Round-robin wrap: rr_ptr=30 (after serving channel 29), requests on 2 and 31.
  - Grant order is 31 then 2.
- mem_busy: request on 7 with mem_busy=1 for 10 cycles.
  - No mem_we and no ack during those cycles.
  - Write occurs 1 cycle after mem_busy falls.
- Done pulse: layer_start_p with exp_wr_cnt=3, then three requests served.
  - layer_wr_done_p pulses once, the cycle after the 3rd write.
  - With exp_wr_cnt=0 it pulses the cycle after layer_start_p.
- Overflow (macro defined): exp_wr_cnt=2, four writes.
  - wr_ovf_err rises on the 3rd write and stays set after a new layer_start_p.
  - With the macro undefined it stays 0.
